// File: rtl/adc_frame_averager.sv
// adc_frame_averager: averages 2^k raw ADC samples and frames them as header/data/trailer
// words for the SRAM data FIFO. Define ADC_FRAME_CHECKSUM_EN to add a per-frame checksum word.
module adc_frame_averager #(
  parameter int          ADC_WIDTH   = 12,
  parameter int          FRAME_LEN   = 256,
  parameter logic [15:0] HEADER_WORD = 16'hEB90
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 iRunStart,
  input  logic [1:0]           set_average_points,
  input  logic [ADC_WIDTH-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic                 fifo_full,
  output logic [15:0]          Dataout,
  output logic                 Dataout_en,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  // state    | meaning
  // IDLE     | waiting for a rising edge of iRunStart
  // HEADER   | emit HEADER_WORD
  // DATA     | accumulate samples, emit one averaged word per 2^k samples
  // CHECKSUM | emit sum of the frame's data words (checksum build only)
  // TRAILER  | emit {truncated, frame_cnt}
`ifdef ADC_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECKSUM, TRAILER} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;
`endif

  localparam logic [14:0] LAST_WORD = 15'(FRAME_LEN - 1);

  state_t      state_q, state_d;
  logic        run_q;
  logic        run_rise;
  logic [1:0]  k_q;
  logic [15:0] acc_q, acc_d, acc_upd, acc_sum;
  logic [3:0]  cnt_q, cnt_d, cnt_upd, n_target;
  logic [14:0] word_cnt_q, word_cnt_d;
  logic [14:0] frame_cnt_q, frame_cnt_d;
  logic        trunc_q, trunc_d;
  logic        accept;
  logic        start;
  logic        word_due;
  logic [15:0] word;
  logic [15:0] avg_word;
  logic [15:0] sample_ext;
`ifdef ADC_FRAME_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  assign run_rise   = iRunStart & ~run_q;
  assign sample_ext = {{(16-ADC_WIDTH){1'b0}}, sample_in};
  assign accept     = sample_valid && iRunStart && (state_q != IDLE);
  assign acc_sum    = acc_q + sample_ext;
  assign acc_upd    = accept ? acc_sum : acc_q;
  assign cnt_upd    = accept ? cnt_q + 4'd1 : cnt_q;
  assign n_target   = 4'd1 << k_q;
  assign avg_word   = acc_upd >> k_q;

  // A block completed in HEADER/TRAILER stays pending until the DATA cycle that follows.
  always_comb begin
    state_d     = state_q;
    word_due    = 1'b0;
    word        = 16'h0000;
    start       = 1'b0;
    acc_d       = acc_upd;
    cnt_d       = cnt_upd;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    trunc_d     = trunc_q;
`ifdef ADC_FRAME_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (run_rise) begin
          start       = 1'b1;
          state_d     = HEADER;
          acc_d       = 16'h0000;
          cnt_d       = 4'd0;
          word_cnt_d  = 15'd0;
          frame_cnt_d = 15'd0;
          trunc_d     = 1'b0;
        end
      end
      HEADER: begin
        word_due   = 1'b1;
        word       = HEADER_WORD;
        word_cnt_d = 15'd0;
`ifdef ADC_FRAME_CHECKSUM_EN
        csum_d     = 16'h0000;
`endif
        if (iRunStart) begin
          state_d = DATA;
        end else begin
          acc_d   = 16'h0000;
          cnt_d   = 4'd0;
          trunc_d = 1'b1;
`ifdef ADC_FRAME_CHECKSUM_EN
          state_d = CHECKSUM;
`else
          state_d = TRAILER;
`endif
        end
      end
      DATA: begin
        if (!iRunStart) begin
          acc_d   = 16'h0000;
          cnt_d   = 4'd0;
          trunc_d = 1'b1;
`ifdef ADC_FRAME_CHECKSUM_EN
          state_d = CHECKSUM;
`else
          word_due    = 1'b1;
          word        = {1'b1, frame_cnt_q};
          frame_cnt_d = frame_cnt_q + 15'd1;
          state_d     = IDLE;
`endif
        end else if (cnt_upd == n_target) begin
          word_due = 1'b1;
          word     = avg_word;
          acc_d    = 16'h0000;
          cnt_d    = 4'd0;
`ifdef ADC_FRAME_CHECKSUM_EN
          csum_d   = csum_q + avg_word;
`endif
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = 15'd0;
`ifdef ADC_FRAME_CHECKSUM_EN
            state_d    = CHECKSUM;
`else
            state_d    = TRAILER;
`endif
          end else begin
            word_cnt_d = word_cnt_q + 15'd1;
          end
        end
      end
`ifdef ADC_FRAME_CHECKSUM_EN
      CHECKSUM: begin
        word_due = 1'b1;
        word     = csum_q;
        state_d  = TRAILER;
      end
`endif
      TRAILER: begin
        word_due    = 1'b1;
        word        = {trunc_q, frame_cnt_q};
        frame_cnt_d = frame_cnt_q + 15'd1;
        trunc_d     = 1'b0;
        if (iRunStart && !trunc_q) begin
          state_d = HEADER;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      k_q         <= 2'd0;
      acc_q       <= 16'h0000;
      cnt_q       <= 4'd0;
      word_cnt_q  <= 15'd0;
      frame_cnt_q <= 15'd0;
      trunc_q     <= 1'b0;
`ifdef ADC_FRAME_CHECKSUM_EN
      csum_q      <= 16'h0000;
`endif
      Dataout     <= 16'h0000;
      Dataout_en  <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      run_q       <= iRunStart;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_q     <= trunc_d;
`ifdef ADC_FRAME_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      if (start) begin
        k_q <= set_average_points;
      end
      Dataout_en <= word_due && !fifo_full;
      if (word_due && !fifo_full) begin
        Dataout <= word;
      end
      // Dropped words still advance the FSM so downstream frame length stays fixed.
      if (start) begin
        overflow   <= 1'b0;
        drop_count <= 16'h0000;
      end else if (word_due && fifo_full) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_averager.sv
// Directed bench for adc_frame_averager with FRAME_LEN=4; expected words are hand-computed
// for both the default and the ADC_FRAME_CHECKSUM_EN builds.
module tb_adc_frame_averager;
  localparam int ADC_W = 12;
  localparam int FL    = 4;
`ifdef ADC_FRAME_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             iRunStart = 1'b0;
  logic [1:0]       set_average_points = 2'd0;
  logic [ADC_W-1:0] sample_in = '0;
  logic             sample_valid = 1'b0;
  logic             fifo_full = 1'b0;
  logic [15:0]      Dataout;
  logic             Dataout_en;
  logic             overflow;
  logic [15:0]      drop_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_sv = 0;
  int sv4 = 0;
  int stop_cyc = 0;
  logic [15:0] got_w[$];
  int          got_c[$];
  logic [15:0] ex[$];

  adc_frame_averager #(.ADC_WIDTH(ADC_W), .FRAME_LEN(FL), .HEADER_WORD(16'hEB90)) dut (
    .clk(clk), .reset_n(reset_n), .iRunStart(iRunStart),
    .set_average_points(set_average_points), .sample_in(sample_in),
    .sample_valid(sample_valid), .fifo_full(fifo_full), .Dataout(Dataout),
    .Dataout_en(Dataout_en), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (Dataout_en === 1'b1) begin
      got_w.push_back(Dataout);
      got_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [ADC_W-1:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    last_sv = cyc;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_gap(input logic [ADC_W-1:0] v);
    pulse(v);
    tick(3);
  endtask

  task automatic start_run(input logic [1:0] k);
    set_average_points = k;
    iRunStart = 1'b1;
    got_w.delete();
    got_c.delete();
    tick(3);
  endtask

  task automatic stop_run();
    iRunStart = 1'b0;
    stop_cyc = cyc;
    tick(8);
  endtask

  task automatic expect_seq(input string tag);
    chk({tag, " word count"}, got_w.size(), ex.size());
    for (int i = 0; i < ex.size(); i++) begin
      if (i < got_w.size()) chk($sformatf("%s word%0d", tag, i), {16'h0, got_w[i]}, {16'h0, ex[i]});
    end
  endtask

  initial begin
    // reset state
    tick(3);
    chk("reset Dataout", {16'h0, Dataout}, 32'h0);
    chk("reset Dataout_en", {31'h0, Dataout_en}, 32'h0);
    chk("reset overflow", {31'h0, overflow}, 32'h0);
    chk("reset drop_count", {16'h0, drop_count}, 32'h0);
    reset_n = 1'b1;
    tick(4);
    chk("idle no output", got_w.size(), 0);

    // Run A: k=0, four samples, continuous run, then stop in DATA
    start_run(2'd0);
    pulse_gap(12'd1); pulse_gap(12'd2); pulse_gap(12'd3); pulse_gap(12'd4);
    stop_run();
    ex = '{16'hEB90, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
`ifdef ADC_FRAME_CHECKSUM_EN
    ex.push_back(16'h000A);
`endif
    ex.push_back(16'h0000);
    ex.push_back(16'hEB90);
`ifdef ADC_FRAME_CHECKSUM_EN
    ex.push_back(16'h0000);
`endif
    ex.push_back(16'h8001);
    expect_seq("runA");
    if (got_c.size() == ex.size()) begin
      chk("runA trailer timing", got_c[5+CS], got_c[4] + 1 + CS);
      chk("runA next header timing", got_c[6+CS], got_c[5+CS] + 1);
      chk("runA truncated trailer timing", got_c[got_c.size()-1], stop_cyc + 1 + 2*CS);
    end

    // Run B: k=2, two averaged words, stop after 2 of 4 words
    start_run(2'd2);
    pulse_gap(12'd10); pulse_gap(12'd11); pulse_gap(12'd12);
    chk("runB partial block no word", got_w.size(), 1);
    pulse_gap(12'd13);
    sv4 = last_sv;
    pulse_gap(12'd0); pulse_gap(12'd1); pulse_gap(12'd2); pulse_gap(12'd3);
    stop_run();
    pulse_gap(12'd7); pulse_gap(12'd7); pulse_gap(12'd7); pulse_gap(12'd7);
    ex = '{16'hEB90, 16'h000B, 16'h0001};
`ifdef ADC_FRAME_CHECKSUM_EN
    ex.push_back(16'h000C);
`endif
    ex.push_back(16'h8000);
    expect_seq("runB");
    if (got_c.size() == ex.size()) begin
      chk("runB avg latency", got_c[1], sv4 + 1);
      chk("runB truncated trailer timing", got_c[got_c.size()-1], stop_cyc + 1 + 2*CS);
    end
    chk("runB overflow", {31'h0, overflow}, 32'h0);

    // Run C: k=3, eight full-scale samples
    start_run(2'd3);
    for (int i = 0; i < 8; i++) pulse_gap(12'hFFF);
    stop_run();
    ex = '{16'hEB90, 16'h0FFF};
`ifdef ADC_FRAME_CHECKSUM_EN
    ex.push_back(16'h0FFF);
`endif
    ex.push_back(16'h8000);
    expect_seq("runC");

    // Run D: k=0, FIFO full during the 2nd data word
    start_run(2'd0);
    pulse_gap(12'd5);
    fifo_full = 1'b1;
    pulse_gap(12'd6);
    fifo_full = 1'b0;
    pulse_gap(12'd7); pulse_gap(12'd8);
    stop_run();
    ex = '{16'hEB90, 16'h0005, 16'h0007, 16'h0008};
`ifdef ADC_FRAME_CHECKSUM_EN
    ex.push_back(16'h001A);
`endif
    ex.push_back(16'h0000);
    ex.push_back(16'hEB90);
`ifdef ADC_FRAME_CHECKSUM_EN
    ex.push_back(16'h0000);
`endif
    ex.push_back(16'h8001);
    expect_seq("runD");
    if (got_c.size() == ex.size()) begin
      chk("runD trailer after 4 slots", got_c[4+CS], got_c[3] + 1 + CS);
    end
    chk("runD overflow", {31'h0, overflow}, 32'h1);
    chk("runD drop_count", {16'h0, drop_count}, 32'h1);

    // Run E: start clears overflow, then async reset mid-run
    start_run(2'd0);
    chk("runE overflow cleared", {31'h0, overflow}, 32'h0);
    chk("runE drop_count cleared", {16'h0, drop_count}, 32'h0);
    fifo_full = 1'b1;
    pulse_gap(12'd9);
    fifo_full = 1'b0;
    chk("runE overflow set", {31'h0, overflow}, 32'h1);
    chk("runE drop_count", {16'h0, drop_count}, 32'h1);
    pulse(12'd3);
    chk("runE word on bus", {16'h0, Dataout}, 32'h3);
    chk("runE strobe on bus", {31'h0, Dataout_en}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset Dataout", {16'h0, Dataout}, 32'h0);
    chk("async reset Dataout_en", {31'h0, Dataout_en}, 32'h0);
    chk("async reset overflow", {31'h0, overflow}, 32'h0);
    chk("async reset drop_count", {16'h0, drop_count}, 32'h0);
    iRunStart = 1'b0;
    tick(2);
    reset_n = 1'b1;
    got_w.delete();
    got_c.delete();
    tick(10);
    chk("no word after reset release", got_w.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
